segm7_scan_decoder: RTL and testbench

- Receive-side counterpart of the binary-to-7-segment encoder.
- Samples a multiplexed 7-segment display bus (segment lines plus one-hot digit enables) and requires each pattern to be stable before capturing it.
- Decodes each captured pattern back to a 4-bit binary value and assembles one value per digit into a frame.
- Presents the frame through a valid/ready handshake. Used for display loopback checking and for reading external 7-segment sources.

---
 rtl/segm7_scan_decoder.sv | 182 ++++++++++++++++++
 tb/tb_segm7_scan_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/segm7_scan_decoder.sv
// Samples a multiplexed 7-segment bus, debounces each digit pattern and assembles decoded frames.
// Optional feature: define SEGM7_BLANK_DETECT_EN to decode the blank pattern as 4'hA.
module segm7_scan_decoder #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    bus_fault
);

    localparam int unsigned KW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]  STABLE_PRE = 8'(STABLE_CYCLES - 1);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_OFFER   = 1'b1;

    // Returns {err, value}.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        logic [4:0] r;
        case (pat)
            7'h7E:   r = {1'b0, 4'h0};
            7'h30:   r = {1'b0, 4'h1};
            7'h6D:   r = {1'b0, 4'h2};
            7'h79:   r = {1'b0, 4'h3};
            7'h33:   r = {1'b0, 4'h4};
            7'h5B:   r = {1'b0, 4'h5};
            7'h5F:   r = {1'b0, 4'h6};
            7'h70:   r = {1'b0, 4'h7};
            7'h7F:   r = {1'b0, 4'h8};
            7'h73:   r = {1'b0, 4'h9};
`ifdef SEGM7_BLANK_DETECT_EN
            7'h00:   r = {1'b0, 4'hA};
`endif
            default: r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    logic [KW-1:0]           ref_k_q, ref_k_d;
    logic [6:0]              ref_seg_q, ref_seg_d;
    logic                    ref_valid_q, ref_valid_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] work_data, work_data_d;
    logic [NUM_DIGITS-1:0]   work_err, work_err_d;
    logic [NUM_DIGITS-1:0]   captured, captured_d;
    logic [0:0]              state_q, state_d;

    logic [4*NUM_DIGITS-1:0] frame_data_d;
    logic [NUM_DIGITS-1:0]   frame_err_d;
    logic                    out_valid_d;
    logic                    bus_fault_d;

    logic                    en_zero;
    logic                    en_onehot;
    logic [KW-1:0]           en_idx;
    logic                    same;
    logic                    capture;
    logic [4:0]              dec;
    logic [NUM_DIGITS-1:0]   mask_next;
    logic                    full;

    always_comb begin
        en_zero   = (digit_en == '0);
        en_onehot = !en_zero && ((digit_en & (digit_en - NUM_DIGITS'(1))) == '0);
        en_idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_en[i]) en_idx = KW'(i);
        end
        same = ref_valid_q && (ref_k_q == en_idx) && (ref_seg_q == seg_in);
    end

    // Stability tracking: capture only on the STABLE_CYCLES-1 -> STABLE_CYCLES step.
    always_comb begin
        cnt_d       = cnt_q;
        ref_k_d     = ref_k_q;
        ref_seg_d   = ref_seg_q;
        ref_valid_d = ref_valid_q;
        capture     = 1'b0;
        if (en_onehot) begin
            if (same) begin
                if (cnt_q != STABLE_MAX) cnt_d = cnt_q + 8'd1;
                capture = (cnt_q == STABLE_PRE);
            end else begin
                cnt_d       = 8'd1;
                ref_k_d     = en_idx;
                ref_seg_d   = seg_in;
                ref_valid_d = 1'b1;
            end
        end else begin
            cnt_d = 8'd0;
        end
        bus_fault_d = bus_fault || (!en_zero && !en_onehot);
    end

    always_comb begin
        dec         = decode(seg_in);
        work_data_d = work_data;
        work_err_d  = work_err;
        mask_next   = captured;
        if (capture) begin
            work_data_d[{en_idx, 2'b00} +: 4] = dec[3:0];
            work_err_d[en_idx]                = dec[4];
            mask_next[en_idx]                 = 1'b1;
        end
        full = &mask_next;
    end

    // Frame FSM: snapshot on mask completion; hold the offered frame until accepted.
    always_comb begin
        state_d      = state_q;
        frame_data_d = frame_data;
        frame_err_d  = frame_err;
        out_valid_d  = out_valid;
        captured_d   = mask_next;
        case (state_q)
            ST_COLLECT: begin
                if (full) begin
                    frame_data_d = work_data_d;
                    frame_err_d  = work_err_d;
                    out_valid_d  = 1'b1;
                    captured_d   = '0;
                    state_d      = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (out_ready) begin
                    if (full) begin
                        frame_data_d = work_data_d;
                        frame_err_d  = work_err_d;
                        captured_d   = '0;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = ST_COLLECT;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_k_q     <= '0;
            ref_seg_q   <= '0;
            ref_valid_q <= 1'b0;
            cnt_q       <= '0;
            work_data   <= '0;
            work_err    <= '0;
            captured    <= '0;
            state_q     <= ST_COLLECT;
            frame_data  <= '0;
            frame_err   <= '0;
            out_valid   <= 1'b0;
            bus_fault   <= 1'b0;
        end else begin
            ref_k_q     <= ref_k_d;
            ref_seg_q   <= ref_seg_d;
            ref_valid_q <= ref_valid_d;
            cnt_q       <= cnt_d;
            work_data   <= work_data_d;
            work_err    <= work_err_d;
            captured    <= captured_d;
            state_q     <= state_d;
            frame_data  <= frame_data_d;
            frame_err   <= frame_err_d;
            out_valid   <= out_valid_d;
            bus_fault   <= bus_fault_d;
        end
    end

endmodule

// File: tb/tb_segm7_scan_decoder.sv
// Directed self-checking bench for segm7_scan_decoder (4 digits, 4-cycle stability).
module tb_segm7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  digit_en;
    logic [15:0] frame_data;
    logic [3:0]  frame_err;
    logic        out_valid;
    logic        out_ready;
    logic        bus_fault;

    int checks = 0;
    int errors = 0;

    segm7_scan_decoder #(
        .NUM_DIGITS   (4),
        .STABLE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .digit_en  (digit_en),
        .frame_data(frame_data),
        .frame_err (frame_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bus_fault (bus_fault)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Present one input vector for n clock cycles; returns 1 time unit after the last edge.
    task automatic drive(input logic [3:0] en, input logic [6:0] seg, input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            digit_en  = en;
            seg_in    = seg;
            out_ready = rdy;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'h0, 7'h00, 1'b0, 1);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        digit_en  = '0;
        seg_in    = '0;
        out_ready = 1'b0;
        drive(4'h0, 7'h00, 1'b0, 2);
        rst = 1'b0;

        check_value("rst_frame_data", 32'(frame_data), 32'h0);
        check_value("rst_frame_err", 32'(frame_err), 32'h0);
        check_value("rst_out_valid", 32'(out_valid), 32'h0);
        check_value("rst_bus_fault", 32'(bus_fault), 32'h0);

        // Capture latency and no repeat while held.
        drive(4'h1, 7'h30, 1'b0, 3);
        check_value("cap_not_yet", 32'(dut.captured), 32'h0);
        drive(4'h1, 7'h30, 1'b0, 1);
        check_value("cap_mask", 32'(dut.captured), 32'h1);
        check_value("cap_slot0", 32'(dut.work_data[3:0]), 32'h1);
        drive(4'h1, 7'h30, 1'b0, 4);
        check_value("cap_held_mask", 32'(dut.captured), 32'h1);
        check_value("cap_valid_low", 32'(out_valid), 32'h0);

        // Full scan 3..0 with consumer stalled.
        do_reset();
        drive(4'h8, 7'h79, 1'b0, 4);
        drive(4'h4, 7'h5B, 1'b0, 4);
        drive(4'h2, 7'h7F, 1'b0, 4);
        check_value("scan_partial_valid", 32'(out_valid), 32'h0);
        drive(4'h1, 7'h7E, 1'b0, 4);
        check_value("scan_valid", 32'(out_valid), 32'h1);
        check_value("scan_data", 32'(frame_data), 32'h3580);
        check_value("scan_err", 32'(frame_err), 32'h0);
        drive(4'h1, 7'h30, 1'b0, 20);
        check_value("stall_data", 32'(frame_data), 32'h3580);
        check_value("stall_valid", 32'(out_valid), 32'h1);
        drive(4'h0, 7'h00, 1'b1, 1);
        check_value("accept_valid", 32'(out_valid), 32'h0);
        check_value("accept_data_kept", 32'(frame_data), 32'h3580);

        // Invalid pattern in slot 1; slot 0 still holds the capture made during the stall.
        drive(4'h2, 7'h01, 1'b0, 4);
        drive(4'h4, 7'h6D, 1'b0, 4);
        drive(4'h8, 7'h70, 1'b0, 4);
        check_value("inv_valid", 32'(out_valid), 32'h1);
        check_value("inv_data", 32'(frame_data), 32'h72F1);
        check_value("inv_err", 32'(frame_err), 32'h2);
        drive(4'h0, 7'h00, 1'b1, 1);
        check_value("inv_accept", 32'(out_valid), 32'h0);

        // Blank pattern in slot 1.
        drive(4'h2, 7'h00, 1'b0, 4);
        drive(4'h1, 7'h33, 1'b0, 4);
        drive(4'h4, 7'h6D, 1'b0, 4);
        drive(4'h8, 7'h70, 1'b0, 4);
        check_value("blank_valid", 32'(out_valid), 32'h1);
`ifdef SEGM7_BLANK_DETECT_EN
        check_value("blank_data", 32'(frame_data), 32'h72A4);
        check_value("blank_err", 32'(frame_err), 32'h0);
`else
        check_value("blank_data", 32'(frame_data), 32'h72F4);
        check_value("blank_err", 32'(frame_err), 32'h2);
`endif
        drive(4'h0, 7'h00, 1'b1, 1);
        check_value("blank_accept", 32'(out_valid), 32'h0);

        // Toggling pattern never stabilises.
        for (int i = 0; i < 4; i++) begin
            drive(4'h1, 7'h30, 1'b0, 2);
            drive(4'h1, 7'h6D, 1'b0, 2);
        end
        check_value("toggle_mask", 32'(dut.captured), 32'h0);
        check_value("toggle_valid", 32'(out_valid), 32'h0);
        check_value("toggle_no_fault", 32'(bus_fault), 32'h0);
        drive(4'h3, 7'h30, 1'b0, 1);
        check_value("fault_set", 32'(bus_fault), 32'h1);
        drive(4'h0, 7'h00, 1'b0, 5);
        check_value("fault_sticky", 32'(bus_fault), 32'h1);

        // Second frame completes on the same cycle the first is accepted.
        drive(4'h8, 7'h79, 1'b0, 4);
        drive(4'h4, 7'h5B, 1'b0, 4);
        drive(4'h2, 7'h7F, 1'b0, 4);
        drive(4'h1, 7'h7E, 1'b0, 4);
        check_value("b2b_first", 32'(frame_data), 32'h3580);
        drive(4'h8, 7'h30, 1'b0, 4);
        drive(4'h4, 7'h6D, 1'b0, 4);
        drive(4'h2, 7'h79, 1'b0, 4);
        drive(4'h1, 7'h33, 1'b0, 3);
        check_value("b2b_hold", 32'(frame_data), 32'h3580);
        drive(4'h1, 7'h33, 1'b1, 1);
        check_value("b2b_valid", 32'(out_valid), 32'h1);
        check_value("b2b_second", 32'(frame_data), 32'h1234);
        drive(4'h0, 7'h00, 1'b0, 2);
        check_value("b2b_still_valid", 32'(out_valid), 32'h1);
        check_value("b2b_fault_kept", 32'(bus_fault), 32'h1);
        drive(4'h0, 7'h00, 1'b1, 1);
        check_value("b2b_drain", 32'(out_valid), 32'h0);

        // Reset mid-frame discards partial captures.
        drive(4'h8, 7'h79, 1'b0, 4);
        drive(4'h4, 7'h5B, 1'b0, 4);
        drive(4'h2, 7'h7F, 1'b0, 4);
        do_reset();
        check_value("mid_rst_data", 32'(frame_data), 32'h0);
        check_value("mid_rst_err", 32'(frame_err), 32'h0);
        check_value("mid_rst_valid", 32'(out_valid), 32'h0);
        check_value("mid_rst_fault", 32'(bus_fault), 32'h0);
        drive(4'h1, 7'h7E, 1'b0, 4);
        check_value("mid_rst_no_frame", 32'(out_valid), 32'h0);
        drive(4'h8, 7'h30, 1'b0, 4);
        drive(4'h4, 7'h6D, 1'b0, 4);
        check_value("mid_rst_partial", 32'(out_valid), 32'h0);
        drive(4'h2, 7'h79, 1'b0, 4);
        check_value("rescan_valid", 32'(out_valid), 32'h1);
        check_value("rescan_data", 32'(frame_data), 32'h1230);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
